neuron_sequencer: RTL and testbench
===================================

# neuron_sequencer

Microcode sequencer for the single-neuron compute loop. On `start` it issues an instruction stream over a valid/ready handshake to the decode/datapath stage:
- clear the accumulator;
- for each of N inputs: load the weight, load the input, and MAC into the accumulator;
- apply the SINN activation;
- store the result.

It sits between the host/test harness and the control-unit decode stage, replacing the instruction-memory fetch while a neuron evaluation is in progress.

## Interface
Parameters:
- `ADDR_W`, 16, width of data-memory addresses and of the `imm` field
- `CNT_W`, 8, width of the input-count field and the loop counter

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  begin a neuron evaluation; sampled only in IDLE
- `abort`  in  1  cancel the sequence; effective in any busy state
- `n_inputs`  in  CNT_W  number of weight/input pairs N; latched on start
- `w_base`  in  ADDR_W  weight vector base address; latched on start
- `x_base`  in  ADDR_W  input vector base address; latched on start
- `y_addr`  in  ADDR_W  result store address; latched on start
- `op_valid`  out  1  the instruction on opcode/rs/rt/rd/imm is valid
- `op_ready`  in  1  downstream accepts the instruction this cycle
- `opcode`  out  4  instruction opcode
- `rs`, `rt`, `rd`  out  3 each  register indices
- `imm`  out  ADDR_W  immediate / absolute address
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- Register allocation is fixed:
  - r0 reads as zero;
  - r1 holds the weight;
  - r2 holds the input;
  - r3 is the accumulator;
  - r4 holds the activation result.
- States: IDLE, CLR, LDW, LDX, MAC, ACT, STO, DONE.
- Instruction issued per state. Fields not listed are 0.
  - CLR: ADD 0001, rs=0, rt=0, rd=3.
  - LDW: LD 1110, rs=0, rt=1, imm=w_base+i.
  - LDX: LD 1110, rs=0, rt=2, imm=x_base+i.
  - MAC: 0100, rs=1, rt=2, rd=3.
  - ACT: SINN 0011, rs=0, rt=3, rd=4 (r4 = 0 < acc).
  - STO: ST 1111, rs=0, rt=4, imm=y_addr.
- Transitions. The "fire" condition is op_valid && op_ready.
  - IDLE→CLR on start. Inputs latched and loop counter i cleared to 0.
  - CLR fire → LDW if N≠0, else → ACT.
  - LDW fire → LDX.
  - LDX fire → MAC.
  - MAC fire → ACT if i==N−1, else → LDW with i+1.
  - ACT fire → STO.
  - STO fire → DONE.
  - DONE → IDLE unconditionally.
- No fire means the state holds.
- Address arithmetic is modulo 2^ADDR_W, so addresses wrap with no error.
- i counts 0..N−1 and is compared against the latched N, never the live input.
- N is unsigned. N=255 (CNT_W=8) yields 255 iterations.
- In IDLE, DONE and reset: op_valid=0, opcode=0000 (NOP), and all fields are 0.
- `busy`=1 in CLR..STO and 0 in IDLE and DONE. `done`=1 only in DONE.
- `start` is ignored while not in IDLE, including in DONE.
- `abort` in any of CLR..STO → IDLE on the next edge. op_valid drops even without a fire. No done pulse is produced. abort has priority over a simultaneous fire.
- `abort` in IDLE or DONE has no effect.
- If start and abort are both asserted in IDLE, start wins.

## Timing
- All outputs are registered (Moore). No combinational path from op_ready to any output.
- Edge 0 samples start. During cycle 1, op_valid=1 and CLR is presented.
- With op_ready held high, the sequence issues 3N+3 instructions, one per cycle, at edges 1..3N+3. done is high for the single cycle after edge 3N+3. The block is back in IDLE after edge 3N+4.
- Handshake: once op_valid rises, opcode/rs/rt/rd/imm stay stable until fire, or until abort/reset. op_valid never drops without a fire except on abort or reset.
- The next instruction, if any, is presented in the cycle after a fire. There are no bubbles.
- rst_n low asynchronously forces:
  - state IDLE, i=0, latched inputs 0;
  - op_valid=0, opcode=0000, fields 0;
  - busy=0, done=0.
- Release is synchronous to the next clk edge.
- Reset mid-sequence discards it, with no done.

## Test plan
- N=3, w_base=0x0100, x_base=0x0200, y_addr=0x0300, op_ready=1 → expect 12 instructions in order:
  - ADD;
  - LD 0x0100, LD 0x0200, MAC;
  - LD 0x0101, LD 0x0201, MAC;
  - LD 0x0102, LD 0x0202, MAC;
  - SINN;
  - ST 0x0300.
  - done pulses in cycle 13; busy high in cycles 1–12.
- N=0, op_ready=1 → ADD, SINN, ST 0x0300; done in cycle 4; no LD/MAC issued.
- N=2, op_ready held low for 4 cycles while LDX (imm=x_base+1) is presented → fields and op_valid stay constant across the stall; the sequence resumes on op_ready; total completion delayed by exactly 4 cycles.
- w_base=0xFFFE, N=3 → weight load addresses 0xFFFE, 0xFFFF, 0x0000.
- Abort and reset:
  - N=4 with abort pulsed during the 2nd MAC → op_valid=0 and IDLE next cycle, no done.
  - A new start then runs a complete sequence.
  - rst_n dropped mid-LDW → outputs zero immediately, without waiting for a clock edge.
- start pulsed while busy (N=2) and again during DONE → both ignored; exactly one done pulse; latched addresses unchanged.

Source files
------------

// File: rtl/neuron_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : neuron_sequencer
//  Purpose  : Microcode sequencer for the single-neuron compute loop. Issues
//             CLR, (LDW, LDX, MAC) x N, ACT, STO over a valid/ready handshake
//             to the decode stage in place of instruction-memory fetch.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_sequencer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_inputs,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] y_addr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [3:0]        opcode,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [ADDR_W-1:0] imm,
    output logic              busy,
    output logic              done
);

    // Opcodes of the instructions this sequencer emits
    localparam logic [3:0] c_OP_NOP  = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_SINN = 4'b0011;
    localparam logic [3:0] c_OP_MAC  = 4'b0100;
    localparam logic [3:0] c_OP_LD   = 4'b1110;
    localparam logic [3:0] c_OP_ST   = 4'b1111;

    // Fixed register allocation
    localparam logic [2:0] c_R_ZERO = 3'd0;
    localparam logic [2:0] c_R_W    = 3'd1;
    localparam logic [2:0] c_R_X    = 3'd2;
    localparam logic [2:0] c_R_ACC  = 3'd3;
    localparam logic [2:0] c_R_ACT  = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_CLR  = 4'd1,
        ST_LDW  = 4'd2,
        ST_LDX  = 4'd3,
        ST_MAC  = 4'd4,
        ST_ACT  = 4'd5,
        ST_STO  = 4'd6,
        ST_DONE = 4'd7
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_i, w_i_nxt;
    logic [CNT_W-1:0]    r_n, w_n_nxt;
    logic [ADDR_W-1:0]   r_w_base, w_w_base_nxt;
    logic [ADDR_W-1:0]   r_x_base, w_x_base_nxt;
    logic [ADDR_W-1:0]   r_y_addr, w_y_addr_nxt;

    logic                r_op_valid, w_op_valid_nxt;
    logic [3:0]          r_opcode, w_opcode_nxt;
    logic [2:0]          r_rs, w_rs_nxt;
    logic [2:0]          r_rt, w_rt_nxt;
    logic [2:0]          r_rd, w_rd_nxt;
    logic [ADDR_W-1:0]   r_imm, w_imm_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;

    logic                w_fire;

    assign w_fire = r_op_valid & op_ready;

    // Next-state, loop counter and operand latch logic
    always_comb begin
        w_state_nxt  = r_state;
        w_i_nxt      = r_i;
        w_n_nxt      = r_n;
        w_w_base_nxt = r_w_base;
        w_x_base_nxt = r_x_base;
        w_y_addr_nxt = r_y_addr;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_CLR;
                    w_i_nxt      = '0;
                    w_n_nxt      = n_inputs;
                    w_w_base_nxt = w_base;
                    w_x_base_nxt = x_base;
                    w_y_addr_nxt = y_addr;
                end
            end
            ST_CLR: begin
                if (w_fire) begin
                    w_state_nxt = (r_n == '0) ? ST_ACT : ST_LDW;
                end
            end
            ST_LDW: begin
                if (w_fire) begin
                    w_state_nxt = ST_LDX;
                end
            end
            ST_LDX: begin
                if (w_fire) begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (w_fire) begin
                    // Compare against the latched count so a changing
                    // n_inputs cannot disturb a running evaluation.
                    if (r_i == (r_n - c_CNT_ONE)) begin
                        w_state_nxt = ST_ACT;
                    end else begin
                        w_state_nxt = ST_LDW;
                        w_i_nxt     = r_i + c_CNT_ONE;
                    end
                end
            end
            ST_ACT: begin
                if (w_fire) begin
                    w_state_nxt = ST_STO;
                end
            end
            ST_STO: begin
                if (w_fire) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides any fire; r_busy is exactly "in CLR..STO".
        if (abort && r_busy) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Instruction decode of the upcoming state so outputs can be registered
    always_comb begin
        w_op_valid_nxt = 1'b0;
        w_opcode_nxt   = c_OP_NOP;
        w_rs_nxt       = c_R_ZERO;
        w_rt_nxt       = c_R_ZERO;
        w_rd_nxt       = c_R_ZERO;
        w_imm_nxt      = '0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (w_state_nxt)
            ST_CLR: begin
                w_op_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_opcode_nxt   = c_OP_ADD;
                w_rd_nxt       = c_R_ACC;
            end
            ST_LDW: begin
                w_op_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_opcode_nxt   = c_OP_LD;
                w_rt_nxt       = c_R_W;
                w_imm_nxt      = w_w_base_nxt + ADDR_W'(w_i_nxt);
            end
            ST_LDX: begin
                w_op_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_opcode_nxt   = c_OP_LD;
                w_rt_nxt       = c_R_X;
                w_imm_nxt      = w_x_base_nxt + ADDR_W'(w_i_nxt);
            end
            ST_MAC: begin
                w_op_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_opcode_nxt   = c_OP_MAC;
                w_rs_nxt       = c_R_W;
                w_rt_nxt       = c_R_X;
                w_rd_nxt       = c_R_ACC;
            end
            ST_ACT: begin
                w_op_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_opcode_nxt   = c_OP_SINN;
                w_rt_nxt       = c_R_ACC;
                w_rd_nxt       = c_R_ACT;
            end
            ST_STO: begin
                w_op_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_opcode_nxt   = c_OP_ST;
                w_rt_nxt       = c_R_ACT;
                w_imm_nxt      = w_y_addr_nxt;
            end
            ST_DONE: begin
                w_done_nxt     = 1'b1;
            end
            default: begin
                w_op_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register, loop counter and latched operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_i      <= '0;
            r_n      <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_y_addr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_n      <= w_n_nxt;
            r_w_base <= w_w_base_nxt;
            r_x_base <= w_x_base_nxt;
            r_y_addr <= w_y_addr_nxt;
        end
    end

    // Registered instruction and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid <= 1'b0;
            r_opcode   <= c_OP_NOP;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_op_valid <= w_op_valid_nxt;
            r_opcode   <= w_opcode_nxt;
            r_rs       <= w_rs_nxt;
            r_rt       <= w_rt_nxt;
            r_rd       <= w_rd_nxt;
            r_imm      <= w_imm_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign op_valid = r_op_valid;
    assign opcode   = r_opcode;
    assign rs       = r_rs;
    assign rt       = r_rt;
    assign rd       = r_rd;
    assign imm      = r_imm;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_sequencer
//  Purpose  : Directed self-checking bench for neuron_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_sequencer;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic              op_ready = 1'b1;
    logic [CNT_W-1:0]  n_inputs = '0;
    logic [ADDR_W-1:0] w_base   = '0;
    logic [ADDR_W-1:0] x_base   = '0;
    logic [ADDR_W-1:0] y_addr   = '0;
    wire               op_valid;
    wire  [3:0]        opcode;
    wire  [2:0]        rs, rt, rd;
    wire  [ADDR_W-1:0] imm;
    wire               busy;
    wire               done;

    int n_cmp = 0;
    int n_err = 0;

    // Packed view of the presented instruction: {valid, opcode, rs, rt, rd, imm}
    wire [29:0] obs = {op_valid, opcode, rs, rt, rd, imm};

    neuron_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .n_inputs (n_inputs),
        .w_base   (w_base),
        .x_base   (x_base),
        .y_addr   (y_addr),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .imm      (imm),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] ins(input logic [3:0] op, input logic [2:0] s,
                                        input logic [2:0] t, input logic [2:0] d,
                                        input logic [15:0] im);
        return {1'b1, op, s, t, d, im};
    endfunction

    // Run one evaluation from IDLE with optional stall and start pokes
    task automatic run_seq(input string tag, input int n, input logic [15:0] w,
                           input logic [15:0] x, input logic [15:0] y,
                           input int stall_idx, input int stall_len,
                           input bit poke, input bit abort_at_start);
        logic [29:0] e[$];
        logic [15:0] a;
        int cyc;
        e.push_back(ins(4'b0001, 3'd0, 3'd0, 3'd3, 16'h0000));
        for (int i = 0; i < n; i++) begin
            a = w + 16'(i);
            e.push_back(ins(4'b1110, 3'd0, 3'd1, 3'd0, a));
            a = x + 16'(i);
            e.push_back(ins(4'b1110, 3'd0, 3'd2, 3'd0, a));
            e.push_back(ins(4'b0100, 3'd1, 3'd2, 3'd3, 16'h0000));
        end
        e.push_back(ins(4'b0011, 3'd0, 3'd3, 3'd4, 16'h0000));
        e.push_back(ins(4'b1111, 3'd0, 3'd4, 3'd0, y));

        n_inputs = n[7:0];
        w_base   = w;
        x_base   = x;
        y_addr   = y;
        start    = 1'b1;
        abort    = abort_at_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc   = 1;
        for (int k = 0; k < e.size(); k++) begin
            chk({tag, " instr"}, 32'(obs), 32'(e[k]));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done-early"}, 32'(done), 32'd0);
            if (k == stall_idx) begin
                op_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    cyc++;
                    chk({tag, " stall hold"}, 32'(obs), 32'(e[k]));
                end
                op_ready = 1'b1;
            end
            if (poke && k == 2) begin
                start    = 1'b1;
                n_inputs = 8'd9;
                w_base   = 16'hDEAD;
                x_base   = 16'hBEEF;
                y_addr   = 16'h5555;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " nop@done"}, 32'(obs), 32'd0);
        chk({tag, " done cycle"}, 32'(cyc), 32'(3 * n + 4 + stall_len));
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " idle done"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle nop"}, 32'(obs), 32'd0);
        @(negedge clk);
        chk({tag, " idle2 done"}, 32'(done), 32'd0);
        chk({tag, " idle2 busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst nop", 32'(obs), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst nop", 32'(obs), 32'd0);

        // Main sequence, empty loop (start beats abort), address wrap, stall
        run_seq("n3", 3, 16'h0100, 16'h0200, 16'h0300, -1, 0, 1'b0, 1'b0);
        run_seq("n0", 0, 16'h0100, 16'h0200, 16'h0300, -1, 0, 1'b0, 1'b1);
        run_seq("wrap", 3, 16'hFFFE, 16'h0200, 16'h0300, -1, 0, 1'b0, 1'b0);
        run_seq("stall", 2, 16'h0100, 16'h0200, 16'h0300, 5, 4, 1'b0, 1'b0);

        // Abort during the second MAC
        n_inputs = 8'd4;
        w_base   = 16'h1000;
        x_base   = 16'h2000;
        y_addr   = 16'h3000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort at mac2", 32'(obs), 32'(ins(4'b0100, 3'd1, 3'd2, 3'd3, 16'h0000)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort nop", 32'(obs), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort no-done", 32'(done), 32'd0);
        run_seq("post-abort", 1, 16'h1000, 16'h2000, 16'h3000, -1, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of LDW
        n_inputs = 8'd2;
        w_base   = 16'h0400;
        x_base   = 16'h0500;
        y_addr   = 16'h0600;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst pre ldw", 32'(obs), 32'(ins(4'b1110, 3'd0, 3'd1, 3'd0, 16'h0400)));
        #2 rst_n = 1'b0;
        #1;
        chk("async rst nop", 32'(obs), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release nop", 32'(obs), 32'd0);
        chk("rst release done", 32'(done), 32'd0);
        run_seq("post-rst", 2, 16'h0400, 16'h0500, 16'h0600, -1, 0, 1'b0, 1'b0);

        // start while busy and during DONE is ignored
        run_seq("start-ignored", 2, 16'h0700, 16'h0800, 16'h0900, -1, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
